// File: rtl/fm_fixed_pkg.sv
// Shared Q10 fixed-point definitions for the FM demod datapath.
// Provides the Q format constants, the fixed_t sample type and round-toward-zero dequantization.
package fm_fixed_pkg;

    localparam int Q_BITS  = 10;
    localparam int Q_ROUND = (1 << Q_BITS) - 1;

    typedef logic signed [31:0] fixed_t;

    // Truncating divide by 2^Q_BITS: bias negatives so the arithmetic shift rounds toward zero.
    function automatic fixed_t dequantize(input fixed_t v);
        fixed_t biased;
        biased = v + (v[31] ? fixed_t'(Q_ROUND) : fixed_t'(0));
        return biased >>> Q_BITS;
    endfunction

endpackage

// File: rtl/multiply.sv
// Combinational Q10 multiply: the product wraps to DATA_WIDTH bits and is then dequantized
// with round-toward-zero. There is no saturation.
module multiply
    import fm_fixed_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] dout
);

    logic signed [DATA_WIDTH-1:0] prod;

    function automatic logic signed [DATA_WIDTH-1:0] round_q(input logic signed [DATA_WIDTH-1:0] v);
        logic signed [DATA_WIDTH-1:0] bias;
        logic signed [DATA_WIDTH-1:0] biased;
        bias   = v[DATA_WIDTH-1] ? DATA_WIDTH'(Q_ROUND) : DATA_WIDTH'(0);
        biased = v + bias;
        return biased >>> Q_BITS;
    endfunction

    // Same-width product: the upper half is dropped, so overflow wraps.
    assign prod = a * b;
    assign dout = round_q(prod);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant logic. It picks the first set request at or after ptr, wrapping at NUM_REQ-1.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                any
);

    always_comb begin
        int                  c;
        logic [ID_WIDTH-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        c         = 0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            c = int'(ptr) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            idx = ID_WIDTH'(c);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one Q10 multiply between NUM_REQ requesters with round-robin arbitration and a tagged,
// registered result. The optional MULT_ARB_PERF_EN macro adds saturating perf_busy/perf_stall counters.
module mult_arbiter
    import fm_fixed_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            in_valid,
    output logic [NUM_REQ-1:0]            in_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_x,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_y,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_WIDTH-1:0]  out_dout,
    output logic [ID_WIDTH-1:0]           out_id
`ifdef MULT_ARB_PERF_EN
    ,
    output logic [31:0]                   perf_busy,
    output logic [31:0]                   perf_stall
`endif
);

    logic [ID_WIDTH-1:0]          rr_ptr;
    logic [NUM_REQ-1:0]           grant;
    logic [ID_WIDTH-1:0]          grant_idx;
    logic                         grant_any;
    logic                         can_accept;
    logic                         xfer;
    logic signed [DATA_WIDTH-1:0] x_sel;
    logic signed [DATA_WIDTH-1:0] y_sel;
    logic signed [DATA_WIDTH-1:0] prod;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign can_accept = !out_valid || out_ready;
    assign in_ready   = (reset_n && can_accept) ? grant : '0;
    assign xfer       = reset_n && can_accept && grant_any;

    // One-hot AND-OR operand mux keyed by the raw grant.
    always_comb begin
        x_sel = '0;
        y_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            x_sel = x_sel | (in_x[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
            y_sel = y_sel | (in_y[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
        end
    end

    multiply #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .a    (x_sel),
        .b    (y_sel),
        .dout (prod)
    );

    // Result stage: a transfer reloads even while draining, so back-to-back results have no bubble.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_dout  <= '0;
            out_id    <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_dout  <= prod;
            out_id    <= grant_idx;
            rr_ptr    <= (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MULT_ARB_PERF_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            if (xfer && perf_busy != '1)
                perf_busy <= perf_busy + 32'd1;
            if (out_valid && !out_ready && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter (NUM_REQ=4, DATA_WIDTH=32).
module tb_mult_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_x;
    logic [N*W-1:0] in_y;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_dout;
    logic [1:0]     out_id;
`ifdef MULT_ARB_PERF_EN
    logic [31:0]    perf_busy;
    logic [31:0]    perf_stall;
`endif

    int checks = 0;
    int passed = 0;

    mult_arbiter #(.DATA_WIDTH(W), .NUM_REQ(N)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dout  (out_dout),
        .out_id    (out_id)
`ifdef MULT_ARB_PERF_EN
        ,
        .perf_busy  (perf_busy),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) $display("FAIL reset_in_ready got=%b want=0000", in_ready);
        else passed++;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_dout !== 32'd0 || out_id !== 2'd0)
            $display("FAIL reset_outputs got v=%b d=%0d id=%0d want v=0 d=0 id=0", out_valid, out_dout, out_id);
        else passed++;
        in_valid = 4'b0000;
        reset_n  = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        in_x[0 +: W] = 32'd3072;
        in_y[0 +: W] = 32'd2048;
        in_valid     = 4'b0001;
        #1;
        checks++;
        if (in_ready !== 4'b0001) $display("FAIL basic_grant got=%b want=0001", in_ready);
        else passed++;
        tick();
        in_valid = 4'b0000;
        checks++;
        if (out_valid !== 1'b1 || $signed(out_dout) !== 32'sd6144 || out_id !== 2'd0)
            $display("FAIL basic_result got v=%b d=%0d id=%0d want v=1 d=6144 id=0", out_valid, $signed(out_dout), out_id);
        else passed++;
        tick();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL basic_drain got v=%b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_round();
        logic signed [W-1:0] xs [3];
        logic signed [W-1:0] ys [3];
        logic signed [W-1:0] exp_d [3];
        xs = '{-32'sd1, -32'sd1536, -32'sd1};
        ys = '{32'sd1, 32'sd1024, 32'sd1536};
        exp_d = '{32'sd0, -32'sd1536, -32'sd1};
        for (int k = 0; k < 3; k++) begin
            in_x[W +: W] = xs[k];
            in_y[W +: W] = ys[k];
            in_valid     = 4'b0010;
            tick();
            checks++;
            if (out_valid !== 1'b1 || $signed(out_dout) !== exp_d[k] || out_id !== 2'd1)
                $display("FAIL round_%0d got v=%b d=%0d id=%0d want v=1 d=%0d id=1",
                         k, out_valid, $signed(out_dout), out_id, exp_d[k]);
            else passed++;
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_fairness();
        logic [1:0] exp_g;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_x[i*W +: W] = (i + 1) * 1024;
            in_y[i*W +: W] = 32'd1024;
        end
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            exp_g = 2'(c % N);
            #1;
            checks++;
            if (in_ready !== (4'b0001 << exp_g)) $display("FAIL fair_grant_%0d got=%b want=%b", c, in_ready, 4'b0001 << exp_g);
            else passed++;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_id !== exp_g || out_dout !== (32'(exp_g) + 32'd1) * 32'd1024)
                $display("FAIL fair_out_%0d got v=%b id=%0d d=%0d want v=1 id=%0d d=%0d",
                         c, out_valid, out_id, out_dout, exp_g, (32'(exp_g) + 32'd1) * 32'd1024);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_id !== 2'd1 || out_dout !== 32'd2048)
                $display("FAIL bp_hold_%0d got rdy=%b v=%b id=%0d d=%0d want rdy=0000 v=1 id=1 d=2048",
                         c, in_ready, out_valid, out_id, out_dout);
            else passed++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) $display("FAIL bp_release_grant got=%b want=0100", in_ready);
        else passed++;
        tick();
        in_valid = 4'b0000;
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd2 || out_dout !== 32'd3072)
            $display("FAIL bp_reload got v=%b id=%0d d=%0d want v=1 id=2 d=3072", out_valid, out_id, out_dout);
        else passed++;
    endtask

    task automatic test_sparse();
        in_valid = 4'b1000;
        #1;
        checks++;
        if (in_ready !== 4'b1000) $display("FAIL sparse_grant3 got=%b want=1000", in_ready);
        else passed++;
        tick();
        in_valid = 4'b0100;
        #1;
        checks++;
        if (in_ready !== 4'b0100) $display("FAIL sparse_grant2 got=%b want=0100", in_ready);
        else passed++;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd2) $display("FAIL sparse_out got v=%b id=%0d want v=1 id=2", out_valid, out_id);
        else passed++;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0000) $display("FAIL sparse_stall got=%b want=0000", in_ready);
        else passed++;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b1000) $display("FAIL sparse_ptr3 got=%b want=1000", in_ready);
        else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        checks++;
        if (out_valid !== 1'b1) $display("FAIL midrst_pre got v=%b want 1", out_valid);
        else passed++;
        reset_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0000) $display("FAIL midrst_in_ready got=%b want=0000", in_ready);
        else passed++;
        tick();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%b want=0", out_valid);
        else passed++;
`ifdef MULT_ARB_PERF_EN
        checks++;
        if (perf_busy !== 32'd0 || perf_stall !== 32'd0)
            $display("FAIL midrst_perf got busy=%0d stall=%0d want 0 0", perf_busy, perf_stall);
        else passed++;
`endif
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) $display("FAIL midrst_first_grant got=%b want=0001", in_ready);
        else passed++;
        in_valid = 4'b0000;
        tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = '0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_round();
        test_fairness();
        test_backpressure();
        test_sparse();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
